// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// bus payload types, TX state encoding and the reset divisor helper.
package uart_mmio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_DIVISOR = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_TWO_STOP = 1;

    typedef struct packed {
        logic [31:0] write_data;
        logic [3:0]  mask_byte;
        logic        mem_read;
    } cmd_t;

    typedef struct packed {
        logic [31:0] read_data;
    } result_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    function automatic int unsigned DEFAULT_DIV(input int unsigned f_clk, input int unsigned baudrate);
        return f_clk / baudrate - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART transmitter: TX FIFO, programmable divisor, status and
// control registers in a four-word window, 8N1/8N2 framing.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned F_CLK      = 25_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] address_in,
    input  logic       we_in,
    input  cmd_t       cmd_in,
    output result_t    result_out,
    output logic       uart_tx_o,
    output logic       irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV(F_CLK, BAUDRATE));

    logic [DIV_WIDTH-1:0] divisor;
    logic                 ctrl_en;
    logic                 ctrl_two_stop;
    logic                 overflow;

    logic                 push_req;
    logic                 pop;
    logic [7:0]           fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    tx_state_t            state, state_d;
    logic [7:0]           shifter, shifter_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic [DIV_WIDTH-1:0] baud_cnt, baud_cnt_d;
    logic [DIV_WIDTH-1:0] div_act, div_act_d;
    logic                 two_stop_act, two_stop_act_d;
    logic                 second_stop, second_stop_d;
    logic                 tx_q, tx_d;
    logic                 irq_q;
    logic                 bit_end;
    logic                 frame_done;
    logic [31:0]          status_word;

    assign push_req = we_in && (address_in == ADDR_DATA) && cmd_in.mask_byte[0];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (cmd_in.write_data[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor       <= RESET_DIV;
            ctrl_en       <= 1'b1;
            ctrl_two_stop <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (we_in) begin
                case (address_in)
                    ADDR_STATUS:
                        if (cmd_in.mask_byte[0] && cmd_in.write_data[ST_OVF]) overflow <= 1'b0;
                    ADDR_DIVISOR:
                        for (int i = 0; i < DIV_WIDTH; i++)
                            if (cmd_in.mask_byte[i/8]) divisor[i] <= cmd_in.write_data[i];
                    ADDR_CTRL:
                        if (cmd_in.mask_byte[0]) begin
                            ctrl_en       <= cmd_in.write_data[CTRL_EN];
                            ctrl_two_stop <= cmd_in.write_data[CTRL_TWO_STOP];
                        end
                    default: ;
                endcase
            end
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latches appear.
    always_comb begin
        state_d        = state;
        shifter_d      = shifter;
        bit_idx_d      = bit_idx;
        baud_cnt_d     = baud_cnt;
        div_act_d      = div_act;
        two_stop_act_d = two_stop_act;
        second_stop_d  = second_stop;
        tx_d           = tx_q;
        pop            = 1'b0;
        frame_done     = 1'b0;
        bit_end        = (baud_cnt == '0);

        if (state != IDLE) baud_cnt_d = bit_end ? div_act : baud_cnt - 1'b1;

        case (state)
            IDLE: ;
            START:
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = shifter[0];
                    shifter_d = shifter >> 1;
                    bit_idx_d = '0;
                end
            DATA:
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d      = shifter[0];
                        shifter_d = shifter >> 1;
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            STOP:
                if (bit_end) begin
                    if (two_stop_act && !second_stop) begin
                        second_stop_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end
            default: state_d = IDLE;
        endcase

        // Starting from the last stop edge keeps back-to-back frames gap-free.
        if ((state == IDLE || frame_done) && ctrl_en && !fifo_empty) begin
            state_d        = START;
            pop            = 1'b1;
            shifter_d      = fifo_dout;
            div_act_d      = divisor;
            two_stop_act_d = ctrl_two_stop;
            second_stop_d  = 1'b0;
            baud_cnt_d     = divisor;
            tx_d           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shifter      <= '0;
            bit_idx      <= '0;
            baud_cnt     <= '0;
            div_act      <= '0;
            two_stop_act <= 1'b0;
            second_stop  <= 1'b0;
            tx_q         <= 1'b1;
            irq_q        <= 1'b1;
        end else begin
            state        <= state_d;
            shifter      <= shifter_d;
            bit_idx      <= bit_idx_d;
            baud_cnt     <= baud_cnt_d;
            div_act      <= div_act_d;
            two_stop_act <= two_stop_act_d;
            second_stop  <= second_stop_d;
            tx_q         <= tx_d;
            irq_q        <= (state == IDLE) && fifo_empty;
        end
    end

    assign uart_tx_o = tx_q;
    assign irq_o     = irq_q;

    always_comb begin
        status_word                        = '0;
        status_word[ST_BUSY]               = (state != IDLE) || !fifo_empty;
        status_word[ST_FULL]               = fifo_full;
        status_word[ST_EMPTY]              = fifo_empty;
        status_word[ST_OVF]                = overflow;
        status_word[ST_COUNT_LSB +: 8]     = 8'(fifo_count);

        result_out = '0;
        if (cmd_in.mem_read) begin
            case (address_in)
                ADDR_STATUS:  result_out.read_data = status_word;
                ADDR_DIVISOR: result_out.read_data = 32'(divisor);
                ADDR_CTRL: begin
                    result_out.read_data[CTRL_EN]       = ctrl_en;
                    result_out.read_data[CTRL_TWO_STOP] = ctrl_two_stop;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped, parametrised UART transmitter. It sits as a slave behind `SlaveBusMux` in place of the fixed-baud, write-only `uart`. It adds a TX FIFO, a runtime-programmable baud divisor, a readable status register, an enable bit, a two-stop-bit mode and a sticky overflow flag. It runs on the CPU clock, so no separate UART clock is needed.

## Interface
Parameters:
- `F_CLK`, 25_000_000, input clock frequency in Hz
- `BAUDRATE`, 115200, baud rate at reset
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two and ≥2
- `DIV_WIDTH`, 16, divisor register width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `address_in`  in  2  word offset within the 4-word window
- `we_in`  in  1  write strobe, qualified by the mux decode
- `cmd_in`  in  MemoryBus::Cmd  uses `write_data`, `mask_byte`, `mem_read`
- `result_out`  out  MemoryBus::Result  read data word
- `uart_tx_o`  out  1  serial line; idle high; registered
- `irq_o`  out  1  high when the FIFO is empty and the shifter is idle

## Operation
Register map (word offsets):
- 0 DATA
  - Write with `mask_byte[0]` set pushes `write_data[7:0]`.
  - Reads return 0.
- 1 STATUS
  - bit0 busy (shifter active or FIFO not empty).
  - bit1 full; bit2 empty; bit3 overflow (sticky).
  - bits[15:8] FIFO count.
  - Writing 1 to bit3 clears overflow; all other bits are read-only.
- 2 DIVISOR: clocks per bit minus 1. Reset value is `F_CLK/BAUDRATE - 1` (216 at the defaults).
- 3 CTRL: bit0 enable (reset 1); bit1 two stop bits (reset 0).

Write rules:
- Register writes honour `mask_byte` per byte lane.
- Reads are side-effect free.

Push rules:
- A push to a full FIFO is dropped and sets overflow.
- A push that coincides with a pop on a full FIFO is accepted; count stays at `FIFO_DEPTH`.

TX state machine, states IDLE, START, DATA, STOP:
- IDLE → START when enable=1 and the FIFO is not empty.
  - Pops one byte into the shifter.
  - Latches DIVISOR and the stop mode into active copies.
- START: drives 0 for one bit time → DATA.
- DATA: sends 8 bits, LSB first, one bit time each; tracked by a 3-bit counter → STOP.
- STOP: drives 1 for 1 or 2 bit times → IDLE.
- A bit time is (active divisor + 1) clocks, counted by a down-counter reloaded at each bit boundary.

Boundary behaviour:
- Clearing enable mid-frame finishes the current frame, then holds IDLE. FIFO contents are kept.
- Writing DIVISOR or CTRL mid-frame affects only the next frame.
- DIVISOR=0 gives 1 clock per bit; this is legal.

## Timing
- Reset values:
  - `uart_tx_o`=1, `irq_o`=1, `result_out`=0.
  - FIFO empty, overflow=0, state IDLE.
- Reset mid-frame: line is high and FIFO empty after the reset edge; any partial frame is abandoned.
- Reads are combinational from `address_in` and registers, so `result_out` is valid in the same cycle as the request.
- Write latency:
  - Write takes effect at the sampling edge.
  - STATUS reflects the new count on the next cycle.
  - Push into an empty FIFO while IDLE: `uart_tx_o` falls one clock after the write edge.
- Frame length: 10 or 11 bit times. Back-to-back frames have no idle gap: STOP → IDLE → START costs 0 extra clocks, because IDLE is exited in the same edge as the STOP end when data is pending.
- `irq_o` is registered and rises the clock after the last stop bit ends with the FIFO empty.

## Structure
- `uart_mmio_pkg` holds:
  - register offset constants and the STATUS/CTRL bit positions;
  - the `tx_state_t` enum;
  - the `DEFAULT_DIV` function of `F_CLK` and `BAUDRATE`.
- Sub-module `sync_fifo`:
  - parameters WIDTH, DEPTH;
  - push/pop with count, full and empty flags;
  - single clock, synchronous reset.
- The top-level generalises `SlaveBusMux` Size2 to 2**2 words for this block.

## Test plan
- Reset, then DIVISOR=3, then write 0x55 to DATA -> `uart_tx_o` shows 0,1,0,1,0,1,0,1,0,1 with each level held for 4 clocks; `irq_o` rises after clock 41.
- CTRL bit1=1 and DIVISOR=1, write 0xA3 -> frame is 0,1,1,0,0,0,1,0,1 followed by a stop high lasting 4 clocks, then IDLE.
- Write 10 bytes back-to-back with enable=0 at depth 8 -> STATUS count=8 and full=1; overflow=1 after the 9th write. Writing 0x8 to STATUS clears overflow. Setting enable=1 transmits exactly the first 8 bytes, gap-free.
- Rewrite DIVISOR from 3 to 7 during the DATA state of frame 1 -> frame 1 keeps 4 clocks/bit and frame 2 uses 8 clocks/bit.
- Assert `rst` for one clock during DATA with 3 bytes queued -> `uart_tx_o`=1, STATUS empty=1 and count=0 on the next cycle, and no further frames.
- DATA write with `mask_byte`=4'b0010 -> no push and count stays 0. DIVISOR write of 0x0000_1234 with mask 4'b0001 -> DIVISOR=0x00_34 over the default upper byte, i.e. 0x0034.
